// File: rtl/bls_pipe_addsub_if.sv
`default_nettype none
// ============================================================================
// Module      : bls_pipe_addsub_if
// Description : Valid/ready operand and result stream bundle for bls_pipe_addsub.
//               The sat field exists only when BLS_SATURATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface bls_pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
`ifdef BLS_SATURATE_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             borrow;
  logic             ovf;
  logic             neg;
  logic             zero;

`ifdef BLS_SATURATE_EN
  modport master (
    output in_valid, a, b, op, sat, out_ready,
    input  in_ready, out_valid, result, borrow, ovf, neg, zero
  );
  modport slave (
    input  in_valid, a, b, op, sat, out_ready,
    output in_ready, out_valid, result, borrow, ovf, neg, zero
  );
`else
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, borrow, ovf, neg, zero
  );
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, borrow, ovf, neg, zero
  );
`endif
endinterface
`default_nettype wire

// File: rtl/bls_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : bls_pipe_addsub
// Description : 2-stage pipelined two-level lookahead add/subtract with flags
//               and valid/ready flow control. Optional macro: BLS_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bls_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  wire                    clk,
  input  wire                    rst,
  bls_pipe_addsub_if.slave       bus
);
  // WIDTH must be a multiple of GROUP and at least 4.
  localparam int NG = WIDTH / GROUP;

  logic             stall;

  // Stage 1 next-state
  logic [WIDTH-1:0] x, y, yv;
  logic [WIDTH-1:0] p_d, g_d;
  logic [NG-1:0]    gp_d, gg_d;
  logic             cin_d;
  logic             acc_p, acc_g;

  // Stage 1 registers
  logic             v1_q;
  logic [WIDTH-1:0] p_q, g_q;
  logic [NG-1:0]    gp_q, gg_q;
  logic             cin_q;
  logic [1:0]       op_q;
`ifdef BLS_SATURATE_EN
  logic             sat_q;
`endif

  // Stage 2 next-state
  logic [NG:0]      gc;
  logic [WIDTH:0]   carry;
  logic             c;
  logic [WIDTH-1:0] raw;
  logic             is_sub;
  logic [WIDTH-1:0] res_d;
  logic             borrow_d, ovf_d, neg_d, zero_d;

  // Stage 2 registers
  logic             v2_q;
  logic [WIDTH-1:0] result_q;
  logic             borrow_q, ovf_q, neg_q, zero_q;

  assign stall        = v2_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  always_comb begin
    x     = (bus.op == 2'b10) ? bus.b : bus.a;
    y     = (bus.op == 2'b10) ? bus.a : bus.b;
    yv    = (bus.op == 2'b01 || bus.op == 2'b10) ? ~y : y;
    cin_d = (bus.op != 2'b00);
    p_d   = x ^ yv;
    g_d   = x & yv;
  end

  always_comb begin
    gp_d  = '0;
    gg_d  = '0;
    acc_p = 1'b0;
    acc_g = 1'b0;
    for (int k = 0; k < NG; k++) begin
      acc_p = 1'b1;
      acc_g = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
        acc_g = g_d[k*GROUP+j] | (p_d[k*GROUP+j] & acc_g);
        acc_p = acc_p & p_d[k*GROUP+j];
      end
      gp_d[k] = acc_p;
      gg_d[k] = acc_g;
    end
  end

  // Second-level lookahead gives each group its carry-in; bits inside a group
  // then use only their own P/G terms.
  always_comb begin
    gc    = '0;
    gc[0] = cin_q;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gg_q[k] | (gp_q[k] & gc[k]);
    end
    carry        = '0;
    carry[WIDTH] = gc[NG];
    c            = 1'b0;
    for (int k = 0; k < NG; k++) begin
      c = gc[k];
      for (int j = 0; j < GROUP; j++) begin
        carry[k*GROUP+j] = c;
        c = g_q[k*GROUP+j] | (p_q[k*GROUP+j] & c);
      end
    end
  end

  always_comb begin
    raw      = p_q ^ carry[WIDTH-1:0];
    is_sub   = (op_q == 2'b01) || (op_q == 2'b10);
    borrow_d = is_sub ? ~carry[WIDTH] : carry[WIDTH];
    ovf_d    = carry[WIDTH-1] ^ carry[WIDTH];
    res_d    = raw;
`ifdef BLS_SATURATE_EN
    if (sat_q && borrow_d) begin
      res_d = is_sub ? '0 : '1;
    end
`endif
    neg_d  = res_d[WIDTH-1];
    zero_d = (res_d == '0);
  end

  // A global stall freezes both stages together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      p_q      <= '0;
      g_q      <= '0;
      gp_q     <= '0;
      gg_q     <= '0;
      cin_q    <= 1'b0;
      op_q     <= 2'b00;
`ifdef BLS_SATURATE_EN
      sat_q    <= 1'b0;
`endif
      v2_q     <= 1'b0;
      result_q <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (!stall) begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        p_q   <= p_d;
        g_q   <= g_d;
        gp_q  <= gp_d;
        gg_q  <= gg_d;
        cin_q <= cin_d;
        op_q  <= bus.op;
`ifdef BLS_SATURATE_EN
        sat_q <= bus.sat;
`endif
      end
      v2_q <= v1_q;
      if (v1_q) begin
        result_q <= res_d;
        borrow_q <= borrow_d;
        ovf_q    <= ovf_d;
        neg_q    <= neg_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.result    = result_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;
  assign bus.neg       = neg_q;
  assign bus.zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_bls_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_bls_pipe_addsub
// Description : Directed self-checking bench for bls_pipe_addsub (WIDTH=16).
//               Saturation vectors run when BLS_SATURATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bls_pipe_addsub;
  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  bls_pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

  bls_pipe_addsub #(.WIDTH(WIDTH), .GROUP(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic sat);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
`ifdef BLS_SATURATE_EN
    bus.sat      = sat;
`else
    if (sat) $display("note: sat ignored in this build");
`endif
  endtask

  // Called at posedge+1; accepts one op and checks it 2 cycles later.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic sat, input logic [15:0] er,
                        input logic eb, input logic eo, input logic en, input logic ez);
    bus.out_ready = 1'b1;
    set_in(1'b1, a, b, op, sat);
    @(posedge clk); #1;
    set_in(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    chk({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"},  32'(bus.out_valid), 32'd1);
    chk({tag, "_result"}, 32'(bus.result),    32'(er));
    chk({tag, "_borrow"}, 32'(bus.borrow),    32'(eb));
    chk({tag, "_ovf"},    32'(bus.ovf),       32'(eo));
    chk({tag, "_neg"},    32'(bus.neg),       32'(en));
    chk({tag, "_zero"},   32'(bus.zero),      32'(ez));
    @(posedge clk); #1;
  endtask

  logic [15:0] s_a   [8];
  logic [15:0] s_b   [8];
  logic [1:0]  s_op  [8];
  logic [15:0] s_exp [8];

  initial begin
    int          idx;
    int          oidx;
    logic        was_stalled;
    logic [15:0] held;

    s_a[0] = 16'h0001; s_b[0] = 16'h0002; s_op[0] = 2'b00; s_exp[0] = 16'h0003;
    s_a[1] = 16'h0010; s_b[1] = 16'h0001; s_op[1] = 2'b01; s_exp[1] = 16'h000F;
    s_a[2] = 16'h0003; s_b[2] = 16'h0010; s_op[2] = 2'b10; s_exp[2] = 16'h000D;
    s_a[3] = 16'h00FF; s_b[3] = 16'h0001; s_op[3] = 2'b11; s_exp[3] = 16'h0101;
    s_a[4] = 16'h1000; s_b[4] = 16'h1000; s_op[4] = 2'b00; s_exp[4] = 16'h2000;
    s_a[5] = 16'h0005; s_b[5] = 16'h0007; s_op[5] = 2'b01; s_exp[5] = 16'hFFFE;
    s_a[6] = 16'h0100; s_b[6] = 16'h0001; s_op[6] = 2'b10; s_exp[6] = 16'hFF01;
    s_a[7] = 16'h1111; s_b[7] = 16'h2222; s_op[7] = 2'b11; s_exp[7] = 16'h3334;

    rst           = 1'b1;
    bus.out_ready = 1'b1;
    set_in(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    32'(bus.result),    32'd0);
    chk("rst_flags",     {28'd0, bus.borrow, bus.ovf, bus.neg, bus.zero}, 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;

    //      tag       a         b         op     sat   result    b  o  n  z
    run_op("sub1",   16'h1234, 16'h0234, 2'b01, 1'b0, 16'h1000, 0, 0, 0, 0);
    run_op("sub0m1", 16'h0000, 16'h0001, 2'b01, 1'b0, 16'hFFFF, 1, 0, 1, 0);
    run_op("rsub",   16'h0000, 16'h0001, 2'b10, 1'b0, 16'h0001, 0, 0, 0, 0);
    run_op("addovf", 16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 0, 1, 1, 0);
    run_op("incadd", 16'hFFFF, 16'h0000, 2'b11, 1'b0, 16'h0000, 1, 0, 0, 1);
    run_op("sub00",  16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0000, 0, 0, 0, 1);
    run_op("addwrap",16'hFFFF, 16'h0001, 2'b00, 1'b0, 16'h0000, 1, 0, 0, 1);
    run_op("subovf", 16'h8000, 16'h0001, 2'b01, 1'b0, 16'h7FFF, 0, 1, 0, 0);
    run_op("carry8", 16'h0F0F, 16'h00F1, 2'b00, 1'b0, 16'h1000, 0, 0, 0, 0);
`ifdef BLS_SATURATE_EN
    run_op("satadd", 16'hFFF0, 16'h0020, 2'b00, 1'b1, 16'hFFFF, 1, 0, 1, 0);
    run_op("satsub", 16'h0005, 16'h0009, 2'b01, 1'b1, 16'h0000, 1, 0, 0, 1);
    run_op("satinc", 16'hFFFF, 16'h0000, 2'b11, 1'b1, 16'hFFFF, 1, 0, 1, 0);
    run_op("satnone",16'h0003, 16'h0004, 2'b00, 1'b1, 16'h0007, 0, 0, 0, 0);
`endif

    // Back-to-back stream with out_ready low in cycles 3..6.
    idx         = 0;
    oidx        = 0;
    was_stalled = 1'b0;
    held        = 16'h0;
    for (int cyc = 0; cyc < 40 && oidx < 8; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      if (idx < 8) set_in(1'b1, s_a[idx], s_b[idx], s_op[idx], 1'b0);
      else         set_in(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
      @(negedge clk);
      chk("stream_in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (was_stalled) chk("stream_hold", 32'(bus.result), 32'(held));
      was_stalled = bus.out_valid && !bus.out_ready;
      held        = bus.result;
      if (bus.out_valid && bus.out_ready) begin
        if (oidx < 8) chk("stream_result", 32'(bus.result), 32'(s_exp[oidx]));
        oidx++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("stream_count", 32'(oidx), 32'd8);
    set_in(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stream_drained", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset with two ops in flight.
    set_in(1'b1, 16'h0100, 16'h0200, 2'b00, 1'b0);
    @(posedge clk); #1;
    set_in(1'b1, 16'h0300, 16'h0400, 2'b00, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid",  32'(bus.out_valid), 32'd0);
    chk("mid_rst_result", 32'(bus.result),    32'd0);
    chk("mid_rst_flags",  {28'd0, bus.borrow, bus.ovf, bus.neg, bus.zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_ghost", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    run_op("post_rst", 16'h0123, 16'h0023, 2'b01, 1'b0, 16'h0100, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
